// File: rtl/wb_commit.sv
// ============================================================================
// Module   : wb_commit
// Purpose  : Writeback commit stage. Arbitrates mux results against load
//            returns for the single regfile write slot, buffering displaced
//            ALU-path results in a small FIFO with forwarding lookup.
// Options  : WB_ZERO_GUARD_EN - suppress integer r0 writes and forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_commit #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_data,
    input  logic [RADDR-1:0] in_rd,
    input  logic             in_is_float,
    input  logic             ld_valid,
    input  logic [XLEN-1:0]  ld_data,
    input  logic [RADDR-1:0] ld_rd,
    input  logic             ld_is_float,
    output logic             ireg_we,
    output logic [RADDR-1:0] ireg_waddr,
    output logic [XLEN-1:0]  ireg_wdata,
    output logic             freg_we,
    output logic [RADDR-1:0] freg_waddr,
    output logic [XLEN-1:0]  freg_wdata,
    input  logic [RADDR-1:0] q_rd,
    input  logic             q_is_float,
    output logic             fwd_hit,
    output logic [XLEN-1:0]  fwd_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [XLEN-1:0]  mem_data_q  [DEPTH];
    logic [XLEN-1:0]  mem_data_d  [DEPTH];
    logic [RADDR-1:0] mem_rd_q    [DEPTH];
    logic [RADDR-1:0] mem_rd_d    [DEPTH];
    logic             mem_flt_q   [DEPTH];
    logic             mem_flt_d   [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    logic             ireg_we_q, ireg_we_d;
    logic [RADDR-1:0] ireg_waddr_q, ireg_waddr_d;
    logic [XLEN-1:0]  ireg_wdata_q, ireg_wdata_d;
    logic             freg_we_q, freg_we_d;
    logic [RADDR-1:0] freg_waddr_q, freg_waddr_d;
    logic [XLEN-1:0]  freg_wdata_q, freg_wdata_d;

    logic             accept, fifo_empty, push, pop;
    logic             sel_valid, sel_flt, sel_int_we;
    logic [XLEN-1:0]  sel_data;
    logic [RADDR-1:0] sel_rd;

    // Ready depends only on the registered count: a full FIFO never takes a
    // push even if the head is popping in the same cycle.
    assign in_ready = rst_n && (count_q < DEPTH_CNT);

    always_comb begin
        accept     = in_valid && in_ready;
        fifo_empty = (count_q == '0);
        pop        = !ld_valid && !fifo_empty;
        push       = accept && (ld_valid || !fifo_empty);

        sel_valid = 1'b0;
        sel_flt   = 1'b0;
        sel_data  = '0;
        sel_rd    = '0;
        if (ld_valid) begin
            sel_valid = 1'b1;
            sel_flt   = ld_is_float;
            sel_data  = ld_data;
            sel_rd    = ld_rd;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_flt   = mem_flt_q[head_q];
            sel_data  = mem_data_q[head_q];
            sel_rd    = mem_rd_q[head_q];
        end else if (accept) begin
            sel_valid = 1'b1;
            sel_flt   = in_is_float;
            sel_data  = in_data;
            sel_rd    = in_rd;
        end

`ifdef WB_ZERO_GUARD_EN
        sel_int_we = sel_valid && !sel_flt && (sel_rd != '0);
`else
        sel_int_we = sel_valid && !sel_flt;
`endif

        ireg_we_d    = sel_int_we;
        freg_we_d    = sel_valid && sel_flt;
        ireg_waddr_d = ireg_waddr_q;
        ireg_wdata_d = ireg_wdata_q;
        freg_waddr_d = freg_waddr_q;
        freg_wdata_d = freg_wdata_q;
        if (sel_valid && !sel_flt) begin
            ireg_waddr_d = sel_rd;
            ireg_wdata_d = sel_data;
        end
        if (sel_valid && sel_flt) begin
            freg_waddr_d = sel_rd;
            freg_wdata_d = sel_data;
        end

        mem_data_d = mem_data_q;
        mem_rd_d   = mem_rd_q;
        mem_flt_d  = mem_flt_q;
        if (push) begin
            mem_data_d[tail_q] = in_data;
            mem_rd_d[tail_q]   = in_rd;
            mem_flt_d[tail_q]  = in_is_float;
        end

        tail_d = tail_q;
        if (push) tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
        head_d = head_q;
        if (pop) head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Scan oldest to newest so the newest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            int idx;
            logic match;
            idx = int'(head_q) + k;
            if (idx >= DEPTH) idx = idx - DEPTH;
            match = (CNT_W'(k) < count_q) && (mem_rd_q[idx] == q_rd)
                    && (mem_flt_q[idx] == q_is_float);
`ifdef WB_ZERO_GUARD_EN
            if (!q_is_float && (q_rd == '0)) match = 1'b0;
`endif
            if (match) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            ireg_we_q    <= 1'b0;
            ireg_waddr_q <= '0;
            ireg_wdata_q <= '0;
            freg_we_q    <= 1'b0;
            freg_waddr_q <= '0;
            freg_wdata_q <= '0;
        end else begin
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            ireg_we_q    <= ireg_we_d;
            ireg_waddr_q <= ireg_waddr_d;
            ireg_wdata_q <= ireg_wdata_d;
            freg_we_q    <= freg_we_d;
            freg_waddr_q <= freg_waddr_d;
            freg_wdata_q <= freg_wdata_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by count/head.
    always_ff @(posedge clk) begin
        mem_data_q <= mem_data_d;
        mem_rd_q   <= mem_rd_d;
        mem_flt_q  <= mem_flt_d;
    end

    assign ireg_we    = ireg_we_q;
    assign ireg_waddr = ireg_waddr_q;
    assign ireg_wdata = ireg_wdata_q;
    assign freg_we    = freg_we_q;
    assign freg_waddr = freg_waddr_q;
    assign freg_wdata = freg_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_commit.sv
// ============================================================================
// Module   : tb_wb_commit
// Purpose  : Scoreboard bench for wb_commit with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_commit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_is_float;
    logic [31:0] in_data;
    logic [4:0]  in_rd;
    logic        ld_valid, ld_is_float;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        ireg_we, freg_we;
    logic [4:0]  ireg_waddr, freg_waddr;
    logic [31:0] ireg_wdata, freg_wdata;
    logic [4:0]  q_rd;
    logic        q_is_float;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    typedef struct packed {
        logic        flt;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    wb_commit #(.XLEN(32), .RADDR(5), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_rd(in_rd), .in_is_float(in_is_float),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_rd(ld_rd),
        .ld_is_float(ld_is_float),
        .ireg_we(ireg_we), .ireg_waddr(ireg_waddr), .ireg_wdata(ireg_wdata),
        .freg_we(freg_we), .freg_waddr(freg_waddr), .freg_wdata(freg_wdata),
        .q_rd(q_rd), .q_is_float(q_is_float),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic wr_t mk(input logic f, input logic [4:0] r, input logic [31:0] d);
        wr_t w;
        w.flt = f; w.rd = r; w.data = d;
        return w;
    endfunction

    // Monitor: every regfile write must match the head of the expected queue.
    always @(negedge clk) begin
        if (ireg_we || freg_we) begin
            wr_t act, req;
            act = ireg_we ? mk(1'b0, ireg_waddr, ireg_wdata) : mk(1'b1, freg_waddr, freg_wdata);
            checks++;
            if (ireg_we && freg_we) begin
                errors++;
                $display("FAIL dual_we actual=both required=one");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=%h required=none", act);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    errors++;
                    $display("FAIL write actual=%h required=%h", act, req);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic f, input logic [4:0] r, input logic [31:0] d);
        in_valid = v; in_is_float = f; in_rd = r; in_data = d;
    endtask

    task automatic set_ld(input logic v, input logic f, input logic [4:0] r, input logic [31:0] d);
        ld_valid = v; ld_is_float = f; ld_rd = r; ld_data = d;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        step();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 5'd0, 32'd0);
        set_ld(1'b0, 1'b0, 5'd0, 32'd0);
        q_rd = 5'd0; q_is_float = 1'b0;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_ireg_we", 32'(ireg_we), 32'd0);
        chk("rst_freg_we", 32'(freg_we), 32'd0);
        chk("rst_ireg_waddr", 32'(ireg_waddr), 32'd0);
        chk("rst_freg_wdata", freg_wdata, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Bypass: one-cycle latency onto the integer port
        exp_q.push_back(mk(1'b0, 5'd3, 32'h12345678));
        set_in(1'b1, 1'b0, 5'd3, 32'h12345678);
        step();
        set_in(1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("byp_ireg_we", 32'(ireg_we), 32'd1);
        chk("byp_ireg_waddr", 32'(ireg_waddr), 32'd3);
        chk("byp_ireg_wdata", ireg_wdata, 32'h12345678);
        chk("byp_freg_we", 32'(freg_we), 32'd0);
        drain("byp_drain");

        // Load priority: three loads overtake A, B; C waits for space
        exp_q.push_back(mk(1'b1, 5'd5, 32'h10000001));
        exp_q.push_back(mk(1'b1, 5'd5, 32'h10000002));
        exp_q.push_back(mk(1'b1, 5'd5, 32'h10000003));
        exp_q.push_back(mk(1'b0, 5'd1, 32'h000000A1));
        exp_q.push_back(mk(1'b0, 5'd2, 32'h000000B2));
        exp_q.push_back(mk(1'b0, 5'd4, 32'h000000C4));
        set_ld(1'b1, 1'b1, 5'd5, 32'h10000001);
        set_in(1'b1, 1'b0, 5'd1, 32'h000000A1);
        chk("lp_ready_c1", 32'(in_ready), 32'd1);
        step();
        set_ld(1'b1, 1'b1, 5'd5, 32'h10000002);
        set_in(1'b1, 1'b0, 5'd2, 32'h000000B2);
        chk("lp_ready_c2", 32'(in_ready), 32'd1);
        step();
        set_ld(1'b1, 1'b1, 5'd5, 32'h10000003);
        set_in(1'b1, 1'b0, 5'd4, 32'h000000C4);
        chk("lp_ready_c3", 32'(in_ready), 32'd0);
        step();
        set_ld(1'b0, 1'b0, 5'd0, 32'd0);
        chk("lp_ready_c4", 32'(in_ready), 32'd0);
        step();
        chk("lp_ready_c5", 32'(in_ready), 32'd1);
        step();
        set_in(1'b0, 1'b0, 5'd0, 32'd0);
        drain("lp_drain");

        // Forwarding: two buffered entries for int r7, newest wins
        exp_q.push_back(mk(1'b0, 5'd9, 32'h90000001));
        exp_q.push_back(mk(1'b0, 5'd9, 32'h90000002));
        exp_q.push_back(mk(1'b0, 5'd9, 32'h90000003));
        exp_q.push_back(mk(1'b0, 5'd7, 32'hAAAA0000));
        exp_q.push_back(mk(1'b0, 5'd7, 32'hBBBB0000));
        set_ld(1'b1, 1'b0, 5'd9, 32'h90000001);
        set_in(1'b1, 1'b0, 5'd7, 32'hAAAA0000);
        step();
        set_ld(1'b1, 1'b0, 5'd9, 32'h90000002);
        set_in(1'b1, 1'b0, 5'd7, 32'hBBBB0000);
        step();
        set_ld(1'b1, 1'b0, 5'd9, 32'h90000003);
        set_in(1'b0, 1'b0, 5'd0, 32'd0);
        q_rd = 5'd7; q_is_float = 1'b0;
        #1;
        chk("fwd_hit_int", 32'(fwd_hit), 32'd1);
        chk("fwd_data_int", fwd_data, 32'hBBBB0000);
        q_is_float = 1'b1;
        #1;
        chk("fwd_hit_flt", 32'(fwd_hit), 32'd0);
        chk("fwd_data_flt", fwd_data, 32'd0);
        q_rd = 5'd8; q_is_float = 1'b0;
        #1;
        chk("fwd_hit_other", 32'(fwd_hit), 32'd0);
        step();
        set_ld(1'b0, 1'b0, 5'd0, 32'd0);
        drain("fwd_drain");

        // Simultaneous push/pop at count 1
        exp_q.push_back(mk(1'b1, 5'd3, 32'h7F000001));
        exp_q.push_back(mk(1'b0, 5'd11, 32'h0000000D));
        exp_q.push_back(mk(1'b0, 5'd12, 32'h0000000E));
        set_ld(1'b1, 1'b1, 5'd3, 32'h7F000001);
        set_in(1'b1, 1'b0, 5'd11, 32'h0000000D);
        step();
        set_ld(1'b0, 1'b0, 5'd0, 32'd0);
        set_in(1'b1, 1'b0, 5'd12, 32'h0000000E);
        chk("pp_ready_before", 32'(in_ready), 32'd1);
        step();
        set_in(1'b0, 1'b0, 5'd0, 32'd0);
        chk("pp_ready_after", 32'(in_ready), 32'd1);
        q_rd = 5'd12; q_is_float = 1'b0;
        #1;
        chk("pp_fwd_new", fwd_data, 32'h0000000E);
        q_rd = 5'd11;
        #1;
        chk("pp_fwd_popped", 32'(fwd_hit), 32'd0);
        drain("pp_drain");

        // Reset mid-operation discards two buffered entries
        exp_q.push_back(mk(1'b0, 5'd13, 32'h0D000001));
        exp_q.push_back(mk(1'b0, 5'd13, 32'h0D000002));
        set_ld(1'b1, 1'b0, 5'd13, 32'h0D000001);
        set_in(1'b1, 1'b0, 5'd14, 32'h0F000001);
        step();
        set_ld(1'b1, 1'b0, 5'd13, 32'h0D000002);
        set_in(1'b1, 1'b0, 5'd15, 32'h0F000002);
        step();
        set_ld(1'b0, 1'b0, 5'd0, 32'd0);
        set_in(1'b0, 1'b0, 5'd0, 32'd0);
        chk("mr_full_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        step();
        chk("mr_rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mr_post_ready", 32'(in_ready), 32'd1);
        q_rd = 5'd14; q_is_float = 1'b0;
        #1;
        chk("mr_fwd_clear", 32'(fwd_hit), 32'd0);
        @(negedge clk);
        chk("mr_ireg_we", 32'(ireg_we), 32'd0);
        chk("mr_freg_we", 32'(freg_we), 32'd0);
        chk("mr_ireg_wdata", ireg_wdata, 32'd0);
        repeat (5) step();
        drain("mr_drain");

        // Integer r0 handling
`ifndef WB_ZERO_GUARD_EN
        exp_q.push_back(mk(1'b0, 5'd0, 32'hFFFFFFFF));
`endif
        set_in(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF);
        chk("r0_ready", 32'(in_ready), 32'd1);
        step();
        set_in(1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
`ifdef WB_ZERO_GUARD_EN
        chk("r0_ireg_we", 32'(ireg_we), 32'd0);
`else
        chk("r0_ireg_we", 32'(ireg_we), 32'd1);
        chk("r0_ireg_waddr", 32'(ireg_waddr), 32'd0);
`endif
        drain("r0_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
